timer_arbiter: RTL and testbench
================================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, the bit width of the shared timer count and load value.
REQ-002 The module SHALL have parameter MAX_HOLD, default 15, the number of idle-expired cycles after which a grant is forcibly revoked.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock, with all state updating on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-005 The module SHALL have port req, input, 2 bits, a level request per requester (bit0 is requester 0, bit1 is requester 1).
REQ-006 The module SHALL have port rel, input, 2 bits, a one-cycle release strobe per requester.
REQ-007 The module SHALL have port req_load, input, 2 bits, the per-requester timer load command.
REQ-008 The module SHALL have port req_en, input, 2 bits, the per-requester timer count enable.
REQ-009 The module SHALL have port req_init, input, 2*WIDTH bits, the per-requester load value, with requester 0 in [WIDTH-1:0].
REQ-010 The module SHALL have port timer_out, input, WIDTH bits, the current count of the shared down-counter.
REQ-011 The module SHALL have port timer_en, output, 1 bit, the count enable driven to the shared timer.
REQ-012 The module SHALL have port timer_load, output, 1 bit, the load command driven to the shared timer.
REQ-013 The module SHALL have port timer_init, output, WIDTH bits, the load value driven to the shared timer.
REQ-014 The module SHALL have port gnt, output, 2 bits, a one-hot-or-zero grant.
REQ-015 The module SHALL have port done, output, 2 bits, indicating that the granted requester's timer has reached zero.
REQ-016 The module SHALL have port abort, output, 2 bits, a one-cycle pulse indicating that a grant was forcibly revoked.

Function
REQ-017 The FSM SHALL have four states: IDLE, GRANT0, GRANT1 and GAP; gnt SHALL be decoded from the state (GRANT0 drives 01, GRANT1 drives 10, otherwise 00).
REQ-018 In IDLE, if exactly one req bit is high, the FSM SHALL grant that requester at the next edge, so gnt rises one cycle after req is sampled.
REQ-019 In IDLE with both req bits high, the requester that is not last_owner SHALL win; last_owner SHALL be updated on every grant entry.
REQ-020 In GRANTi, timer_en, timer_load and timer_init SHALL be combinationally muxed from req_en[i], req_load[i] and req_init slice i, with zero latency.
REQ-021 In IDLE and GAP, timer_en, timer_load and timer_init SHALL all be 0.
REQ-022 done[i] SHALL equal gnt[i] AND (timer_out == 0), combinationally; done SHALL be 00 whenever no grant is held.
REQ-023 rel[i] sampled in GRANTi SHALL move the FSM to GAP at the next edge.
REQ-024 rel asserted by a non-owner, or asserted in IDLE or GAP, SHALL be ignored.
REQ-025 Deasserting req[i] while in GRANTi SHALL NOT release the grant; only rel or the watchdog releases it.
REQ-026 GAP SHALL last exactly one cycle, then apply the REQ-018/019 arbitration to the current req bits, going to GRANTx or to IDLE.
REQ-027 A requester SHALL be able to re-acquire the grant directly after GAP if the other requester is not requesting.
REQ-028 A WIDTH-independent hold counter SHALL clear on entry to GRANTi and on any cycle with timer_out != 0, and SHALL increment on each GRANTi cycle with timer_out == 0.
REQ-029 When the hold counter reaches MAX_HOLD, the FSM SHALL go to GAP at the next edge and pulse abort[i] high for that one GAP cycle.
REQ-030 If rel[i] and the watchdog trip occur in the same cycle, the release SHALL be treated as normal and abort SHALL stay 0.
REQ-031 An illegal state SHALL recover to IDLE at the next edge with all outputs 0.

Reset
REQ-032 While rst is low, the state SHALL be IDLE, last_owner SHALL be 1 (so requester 0 wins the first tie), the hold counter SHALL be 0, and gnt, abort, done, timer_en, timer_load and timer_init SHALL all be 0, taking effect asynchronously.
REQ-033 Reset asserted mid-grant SHALL drop gnt immediately, and no abort SHALL be generated.
REQ-034 After rst is released, arbitration SHALL begin at the first rising edge.

Verification
REQ-035 A bench SHALL cover: after reset, req=11 -> gnt=01 after 1 edge; then rel=01 -> gnt=00 (GAP) for 1 cycle, then gnt=10.
REQ-036 A bench SHALL cover: in GRANT0 with req_load0=1 and req_init0=4'hA -> timer_load=1 and timer_init=A in the same cycle; requester 1 inputs SHALL have no effect on the outputs.
REQ-037 A bench SHALL cover: in GRANT1 with timer_out=0 -> done=10; with no rel for 15 cycles -> GAP with abort=10 for 1 cycle, then gnt=00.
REQ-038 A bench SHALL cover: rel=10 issued while gnt=01 -> no change; req0 dropped while granted -> gnt stays 01.
REQ-039 A bench SHALL cover: rst pulled low mid-GRANT0 -> all outputs 0 immediately; after release with req=11 -> requester 0 granted.
REQ-040 A bench SHALL cover: rel0 and the watchdog trip in the same cycle -> GAP with abort=00.

Source files
------------

// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
//   Arbitrates two requesters for one shared down-counting timer. The owner
//   of the grant drives the timer's enable/load/init inputs directly (zero
//   latency mux) and sees the timer reaching zero on its done bit. A grant
//   ends on a release strobe from the owner or, if the timer sits at zero
//   too long, through a watchdog that revokes it and pulses abort. Every
//   grant is followed by a one-cycle GAP before the next arbitration.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous reset, active low
//   req[1:0]   : level request per requester
//   rel[1:0]   : one-cycle release strobe per requester (owner only)
//   req_load   : per-requester timer load command
//   req_en     : per-requester timer count enable
//   req_init   : per-requester load value, requester 0 in [WIDTH-1:0]
//   timer_out  : current count of the shared timer
//   timer_en   : count enable to the shared timer
//   timer_load : load command to the shared timer
//   timer_init : load value to the shared timer
//   gnt[1:0]   : one-hot-or-zero grant
//   done[1:0]  : owner's timer has reached zero
//   abort[1:0] : one-cycle pulse in GAP after a watchdog revocation
// -----------------------------------------------------------------------------
module timer_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [1:0]         rel,
    input  logic [1:0]         req_load,
    input  logic [1:0]         req_en,
    input  logic [2*WIDTH-1:0] req_init,
    input  logic [WIDTH-1:0]   timer_out,
    output logic               timer_en,
    output logic               timer_load,
    output logic [WIDTH-1:0]   timer_init,
    output logic [1:0]         gnt,
    output logic [1:0]         done,
    output logic [1:0]         abort
);

    // Hold counter is sized from MAX_HOLD alone, independent of WIDTH.
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              last_owner;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        abort_r;

    logic granted;
    logic cnt_zero;
    logic owner_rel;
    logic trip;

    assign granted   = (state == GRANT0) || (state == GRANT1);
    assign cnt_zero  = (timer_out == '0);
    assign owner_rel = ((state == GRANT0) && rel[0]) || ((state == GRANT1) && rel[1]);
    // Watchdog fires on the cycle the zero-hold count would reach MAX_HOLD.
    assign trip      = granted && cnt_zero && (hold_cnt == HOLD_LAST);

    // On a tie the requester that did not own the previous grant wins.
    function automatic state_t arbitrate(input logic [1:0] r, input logic last);
        state_t s;
        case (r)
            2'b01:   s = GRANT0;
            2'b10:   s = GRANT1;
            2'b11:   s = last ? GRANT0 : GRANT1;
            default: s = IDLE;
        endcase
        return s;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE, GAP: next_state = arbitrate(req, last_owner);
            GRANT0:    next_state = (rel[0] || trip) ? GAP : GRANT0;
            GRANT1:    next_state = (rel[1] || trip) ? GAP : GRANT1;
            default:   next_state = IDLE;
        endcase
    end

    // Ownership history, watchdog counter and abort flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= 1'b1;
            hold_cnt   <= '0;
            abort_r    <= 2'b00;
        end else begin
            if (next_state == GRANT0 && state != GRANT0) begin
                last_owner <= 1'b0;
            end else if (next_state == GRANT1 && state != GRANT1) begin
                last_owner <= 1'b1;
            end

            // Outside a grant the counter is held at zero, which also makes
            // every grant entry start from zero.
            if (granted && cnt_zero) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end

            // A release in the trip cycle wins: that grant ends normally.
            if (trip && !owner_rel) begin
                abort_r <= {state == GRANT1, state == GRANT0};
            end else begin
                abort_r <= 2'b00;
            end
        end
    end

    // Output decode
    always_comb begin
        gnt        = 2'b00;
        done       = 2'b00;
        abort      = 2'b00;
        timer_en   = 1'b0;
        timer_load = 1'b0;
        timer_init = '0;
        case (state)
            GRANT0: begin
                gnt        = 2'b01;
                done       = {1'b0, cnt_zero};
                timer_en   = req_en[0];
                timer_load = req_load[0];
                timer_init = req_init[WIDTH-1:0];
            end
            GRANT1: begin
                gnt        = 2'b10;
                done       = {cnt_zero, 1'b0};
                timer_en   = req_en[1];
                timer_load = req_load[1];
                timer_init = req_init[2*WIDTH-1:WIDTH];
            end
            GAP: begin
                abort = abort_r;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;

    localparam int W  = 4;
    localparam int MH = 15;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [1:0]     req = 2'b00;
    logic [1:0]     rel = 2'b00;
    logic [1:0]     req_load = 2'b00;
    logic [1:0]     req_en = 2'b00;
    logic [2*W-1:0] req_init = '0;
    logic [W-1:0]   timer_out = '0;
    logic           timer_en;
    logic           timer_load;
    logic [W-1:0]   timer_init;
    logic [1:0]     gnt;
    logic [1:0]     done;
    logic [1:0]     abort;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the timer, whether we sit in the gap cycle,
    // who owned last, how many consecutive zero-count cycles the owner held.
    int         m_owner = -1;
    bit         m_gap   = 1'b0;
    int         m_last  = 1;
    int         m_hold  = 0;
    logic [1:0] m_abort = 2'b00;

    always #5 clk = ~clk;

    timer_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .rel        (rel),
        .req_load   (req_load),
        .req_en     (req_en),
        .req_init   (req_init),
        .timer_out  (timer_out),
        .timer_en   (timer_en),
        .timer_load (timer_load),
        .timer_init (timer_init),
        .gnt        (gnt),
        .done       (done),
        .abort      (abort)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_gap   = 1'b0;
        m_last  = 1;
        m_hold  = 0;
        m_abort = 2'b00;
    endtask

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b11) return (m_last == 1) ? 0 : 1;
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (m_owner >= 0) begin
            if (rel[m_owner]) begin
                m_owner = -1; m_gap = 1'b1; m_abort = 2'b00; m_hold = 0;
            end else if (timer_out == 0 && m_hold + 1 >= MH) begin
                m_abort = 2'(1 << m_owner);
                m_owner = -1; m_gap = 1'b1; m_hold = 0;
            end else begin
                m_hold = (timer_out == 0) ? m_hold + 1 : 0;
            end
        end else begin
            w = pick(req);
            m_gap = 1'b0;
            m_abort = 2'b00;
            if (w >= 0) begin
                m_owner = w; m_last = w; m_hold = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 2'b11; rel = 2'b11; req_load = 2'b11; req_en = 2'b11;
        req_init = 8'hFF; timer_out = '0;
        tick();
        n_tests++;
        if ({gnt, done, abort, timer_en, timer_load, timer_init} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b done=%b abort=%b en=%b ld=%b init=%h required all 0",
                     gnt, done, abort, timer_en, timer_load, timer_init);
        end
        req = 2'b00; rel = 2'b00; req_load = 2'b00; req_en = 2'b00; req_init = '0;
        timer_out = 4'd5;
        rst = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 2'b00) begin
            n_fail++; $display("FAIL reset_release_idle: gnt=%b required 00", gnt);
        end
    endtask

    task automatic test_tie_release();
        req = 2'b11;
        #1;
        n_tests++;
        if (gnt !== 2'b00) begin
            n_fail++; $display("FAIL tie_before_edge: gnt=%b required 00", gnt);
        end
        tick();
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++; $display("FAIL tie_first_grant: gnt=%b required 01", gnt);
        end
        rel = 2'b01;
        tick();
        rel = 2'b00;
        n_tests++;
        if (gnt !== 2'b00 || abort !== 2'b00) begin
            n_fail++; $display("FAIL release_gap: gnt=%b abort=%b required 00 00", gnt, abort);
        end
        tick();
        n_tests++;
        if (gnt !== 2'b10) begin
            n_fail++; $display("FAIL gap_then_other: gnt=%b required 10", gnt);
        end
        rel = 2'b10;
        tick();
        rel = 2'b00; req = 2'b00;
        tick();
        n_tests++;
        if (gnt !== 2'b00) begin
            n_fail++; $display("FAIL back_to_idle: gnt=%b required 00", gnt);
        end
    endtask

    task automatic test_mux();
        timer_out = 4'd3;
        req = 2'b01;
        tick();
        req_load = 2'b01; req_en = 2'b10; req_init = {4'h5, 4'hA};
        #1;
        n_tests++;
        if ({gnt, timer_load, timer_en, timer_init} !== {2'b01, 1'b1, 1'b0, 4'hA}) begin
            n_fail++;
            $display("FAIL mux_owner0: gnt=%b ld=%b en=%b init=%h required 01 1 0 a",
                     gnt, timer_load, timer_en, timer_init);
        end
        req_load = 2'b11; req_init = {4'hF, 4'hA}; req_en = 2'b01;
        #1;
        n_tests++;
        if ({timer_load, timer_en, timer_init, done} !== {1'b1, 1'b1, 4'hA, 2'b00}) begin
            n_fail++;
            $display("FAIL mux_isolation: ld=%b en=%b init=%h done=%b required 1 1 a 00",
                     timer_load, timer_en, timer_init, done);
        end
        req_load = 2'b10; req_en = 2'b10;
        #1;
        n_tests++;
        if ({timer_load, timer_en} !== 2'b00) begin
            n_fail++; $display("FAIL mux_other_ignored: ld=%b en=%b required 0 0", timer_load, timer_en);
        end
        req_load = 2'b00; req_en = 2'b00; req_init = '0;
        rel = 2'b01; req = 2'b00;
        tick();
        rel = 2'b00;
        tick();
    endtask

    task automatic test_watchdog();
        req = 2'b10;
        tick();
        timer_out = 4'd0;
        #1;
        n_tests++;
        if (done !== 2'b10) begin
            n_fail++; $display("FAIL done_owner1: done=%b required 10", done);
        end
        for (int k = 0; k < MH - 1; k++) begin
            tick();
            n_tests++;
            if (gnt !== 2'b10 || abort !== 2'b00) begin
                n_fail++; $display("FAIL watchdog_hold_%0d: gnt=%b abort=%b required 10 00", k, gnt, abort);
            end
        end
        tick();
        req = 2'b00;
        #1;
        n_tests++;
        if ({gnt, abort, done} !== {2'b00, 2'b10, 2'b00}) begin
            n_fail++; $display("FAIL watchdog_abort: gnt=%b abort=%b done=%b required 00 10 00", gnt, abort, done);
        end
        tick();
        n_tests++;
        if (gnt !== 2'b00 || abort !== 2'b00) begin
            n_fail++; $display("FAIL abort_one_cycle: gnt=%b abort=%b required 00 00", gnt, abort);
        end
    endtask

    task automatic test_ignore_rel();
        timer_out = 4'd7;
        rel = 2'b11;
        tick();
        rel = 2'b00;
        n_tests++;
        if (gnt !== 2'b00) begin
            n_fail++; $display("FAIL rel_in_idle: gnt=%b required 00", gnt);
        end
        req = 2'b01;
        tick();
        rel = 2'b10;
        tick();
        rel = 2'b00;
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++; $display("FAIL nonowner_rel: gnt=%b required 01", gnt);
        end
        req = 2'b00;
        tick();
        tick();
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++; $display("FAIL req_drop_keeps: gnt=%b required 01", gnt);
        end
        rel = 2'b01;
        tick();
        rel = 2'b00;
        tick();
    endtask

    task automatic test_async_reset();
        req = 2'b01;
        tick();
        req_en = 2'b01; req_load = 2'b01; req_init = 8'h0A; timer_out = 4'd0;
        #1;
        n_tests++;
        if ({gnt, done, timer_en, timer_load} !== 6'b01_01_1_1) begin
            n_fail++; $display("FAIL pre_reset_active: gnt=%b done=%b en=%b ld=%b required 01 01 1 1",
                               gnt, done, timer_en, timer_load);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({gnt, done, abort, timer_en, timer_load, timer_init} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b done=%b abort=%b en=%b ld=%b init=%h required all 0",
                     gnt, done, abort, timer_en, timer_load, timer_init);
        end
        tick();
        req = 2'b11; req_en = 2'b00; req_load = 2'b00; req_init = '0; timer_out = 4'd2;
        rst = 1'b1;
        tick();
        n_tests++;
        if (gnt !== 2'b01 || abort !== 2'b00) begin
            n_fail++; $display("FAIL post_reset_tie: gnt=%b abort=%b required 01 00", gnt, abort);
        end
        rel = 2'b01; req = 2'b00;
        tick();
        rel = 2'b00;
        tick();
    endtask

    task automatic test_rel_trip();
        req = 2'b01;
        tick();
        timer_out = 4'd0;
        for (int k = 0; k < MH - 1; k++) tick();
        rel = 2'b01; req = 2'b00;
        tick();
        rel = 2'b00;
        n_tests++;
        if (gnt !== 2'b00 || abort !== 2'b00) begin
            n_fail++; $display("FAIL rel_with_trip: gnt=%b abort=%b required 00 00", gnt, abort);
        end
        tick();
    endtask

    task automatic test_random();
        logic [11:0] exp_v;
        logic [11:0] act_v;
        logic [1:0]  e_gnt;
        logic        e_en;
        logic        e_ld;
        logic [W-1:0] e_init;
        logic [1:0]  e_done;
        logic [1:0]  e_abort;
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            req      = 2'($urandom);
            rel[0]   = ($urandom_range(0, 15) == 0);
            rel[1]   = ($urandom_range(0, 15) == 0);
            req_load = 2'($urandom);
            req_en   = 2'($urandom);
            req_init = 8'($urandom);
            if (((cyc / 60) % 2) == 0)
                timer_out = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'd0;
            else
                timer_out = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            if (!rst) model_reset();
            #1;
            e_gnt   = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
            e_en    = (m_owner >= 0) ? req_en[m_owner] : 1'b0;
            e_ld    = (m_owner >= 0) ? req_load[m_owner] : 1'b0;
            e_init  = (m_owner >= 0) ? req_init[m_owner*W +: W] : '0;
            e_done  = (m_owner >= 0 && timer_out == 0) ? e_gnt : 2'b00;
            e_abort = m_gap ? m_abort : 2'b00;
            exp_v = {e_gnt, e_done, e_abort, e_en, e_ld, e_init};
            act_v = {gnt, done, abort, timer_en, timer_load, timer_init};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL random_cyc%0d: {gnt,done,abort,en,ld,init}=%b required %b", cyc, act_v, exp_v);
            end
            if (rst) model_step();
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_tie_release();
        test_mux();
        test_watchdog();
        test_ignore_rel();
        test_async_reset();
        test_rel_trip();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
